// File: rtl/ps2_code_encode.sv
// PS/2 keyboard receiver that turns recognised make codes into one-cycle
// 4-bit command strobes for the VGA character control logic.
module ps2_code_encode #(
    parameter logic [15:0] TIMEOUT   = 16'd50000,
    parameter logic [3:0]  IDLE_CODE = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clock,
    input  logic       ps2Data,
    output logic [3:0] inCode,
    output logic       codeValid,
    output logic       frameError
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // True when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Returns {hit, code} for a final byte given the extended-prefix state.
    function automatic logic [4:0] map_code(input logic [7:0] b, input logic ext);
        logic [4:0] r;
        case ({ext, b})
            9'h045:  r = {1'b1, 4'h0};
            9'h016:  r = {1'b1, 4'h1};
            9'h01E:  r = {1'b1, 4'h2};
            9'h026:  r = {1'b1, 4'h3};
            9'h02D:  r = {1'b1, 4'h4};
            9'h034:  r = {1'b1, 4'h5};
            9'h032:  r = {1'b1, 4'h6};
            9'h175:  r = {1'b1, 4'h7};
            9'h172:  r = {1'b1, 4'h8};
            9'h16B:  r = {1'b1, 4'h9};
            9'h174:  r = {1'b1, 4'hA};
            9'h079:  r = {1'b1, 4'hB};
            9'h07B:  r = {1'b1, 4'hC};
            9'h02B:  r = {1'b1, 4'hD};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic       clk_sync1_r;
    logic       clk_sync2_r;
    logic       clk_prev_r;
    logic       data_sync1_r;
    logic       data_sync2_r;
    logic       fall_s;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] shift_r;
    logic [7:0] shift_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_s;
    logic       parity_r;
    logic       parity_s;
    logic       ext_r;
    logic       ext_s;
    logic       brk_r;
    logic       brk_s;
    logic [15:0] tmo_cnt_r;

    logic       strobe_s;
    logic [3:0] code_s;
    logic       error_s;
    logic [4:0] map_s;

    logic [3:0] in_code_r;
    logic       code_valid_r;
    logic       frame_error_r;

    assign fall_s = clk_prev_r & ~clk_sync2_r;
    assign map_s  = map_code(shift_r, ext_r);

    // Synchronisers, clock-edge history and the saturating timeout counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_sync1_r  <= 1'b1;
            clk_sync2_r  <= 1'b1;
            clk_prev_r   <= 1'b1;
            data_sync1_r <= 1'b1;
            data_sync2_r <= 1'b1;
            tmo_cnt_r    <= 16'd0;
        end else begin
            clk_sync1_r  <= ps2Clock;
            clk_sync2_r  <= clk_sync1_r;
            clk_prev_r   <= clk_sync2_r;
            data_sync1_r <= ps2Data;
            data_sync2_r <= data_sync1_r;
            if (fall_s) begin
                tmo_cnt_r <= 16'd0;
            end else if (tmo_cnt_r != TIMEOUT) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

    // Frame FSM state, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= IDLE;
            shift_r       <= 8'h00;
            bit_cnt_r     <= 3'd0;
            parity_r      <= 1'b0;
            ext_r         <= 1'b0;
            brk_r         <= 1'b0;
            in_code_r     <= IDLE_CODE;
            code_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            shift_r       <= shift_s;
            bit_cnt_r     <= bit_cnt_s;
            parity_r      <= parity_s;
            ext_r         <= ext_s;
            brk_r         <= brk_s;
            in_code_r     <= strobe_s ? code_s : IDLE_CODE;
            code_valid_r  <= strobe_s;
            frame_error_r <= error_s;
        end
    end

    // Next-state, byte assembly, prefix tracking and strobe decode.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        parity_s  = parity_r;
        ext_s     = ext_r;
        brk_s     = brk_r;
        strobe_s  = 1'b0;
        code_s    = IDLE_CODE;
        error_s   = 1'b0;
        if (fall_s) begin
            case (state_r)
                IDLE: begin
                    if (!data_sync2_r) begin
                        state_s   = DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        error_s = 1'b1;
                    end
                end
                DATA: begin
                    shift_s   = {data_sync2_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = (bit_cnt_r == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    parity_s = data_sync2_r;
                    state_s  = STOP;
                end
                STOP: begin
                    state_s = IDLE;
                    if (data_sync2_r && odd_parity_ok(shift_r, parity_r)) begin
                        if (shift_r == 8'hE0) begin
                            ext_s = 1'b1;
                        end else if (shift_r == 8'hF0) begin
                            brk_s = 1'b1;
                        end else begin
                            ext_s    = 1'b0;
                            brk_s    = 1'b0;
                            // A release (break prefix seen) never strobes.
                            strobe_s = map_s[4] & ~brk_r;
                            code_s   = map_s[4] ? map_s[3:0] : IDLE_CODE;
                        end
                    end else begin
                        error_s = 1'b1;
                        ext_s   = 1'b0;
                        brk_s   = 1'b0;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if ((state_r != IDLE) && (tmo_cnt_r == TIMEOUT)) begin
            state_s = IDLE;
            error_s = 1'b1;
            ext_s   = 1'b0;
            brk_s   = 1'b0;
        end else begin
            state_s = state_r;
        end
    end

    assign inCode     = in_code_r;
    assign codeValid  = code_valid_r;
    assign frameError = frame_error_r;

endmodule

// File: tb/tb_ps2_code_encode.sv
// Directed bench for ps2_code_encode: table of PS/2 bytes with expected
// strobes/errors, plus hand sequences for latency, timeout and mid-frame reset.
module tb_ps2_code_encode;

    localparam logic [15:0] TMO = 16'd200;

    logic       clock;
    logic       reset;
    logic       ps2Clock;
    logic       ps2Data;
    logic [3:0] inCode;
    logic       codeValid;
    logic       frameError;

    ps2_code_encode #(.TIMEOUT(TMO), .IDLE_CODE(4'hF)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2Clock   (ps2Clock),
        .ps2Data    (ps2Data),
        .inCode     (inCode),
        .codeValid  (codeValid),
        .frameError (frameError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int viol_cnt = 0;
    int strobe_cyc = 0;
    int stop_fall_cyc = 0;
    logic [3:0] last_code = 4'h0;
    logic prev_cv = 1'b0;
    logic prev_fe = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: counts pulses and flags protocol violations.
    always @(negedge clock) begin
        if (codeValid) begin
            strobe_cnt = strobe_cnt + 1;
            last_code  = inCode;
            strobe_cyc = cyc;
            if (inCode == 4'hF) viol_cnt = viol_cnt + 1;
            if (prev_cv) viol_cnt = viol_cnt + 1;
        end else if (inCode != 4'hF) begin
            viol_cnt = viol_cnt + 1;
        end
        if (frameError) begin
            err_cnt = err_cnt + 1;
            if (prev_fe) viol_cnt = viol_cnt + 1;
        end
        prev_cv = codeValid;
        prev_fe = frameError;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Sends the first nbits of an 11-bit frame (start, 8 data, parity, stop).
    task automatic send_bits(input logic [7:0] d, input logic bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2Data = fr[i];
            wclk(8);
            ps2Clock = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wclk(16);
            ps2Clock = 1'b1;
            wclk(8);
        end
        ps2Data = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       bad;
        int         exp_strobes;
        logic [3:0] exp_code;
        int         exp_errs;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] d, input logic bad, input int s,
                       input logic [3:0] c, input int e);
        vec_t v;
        v.data = d; v.bad = bad; v.exp_strobes = s; v.exp_code = c; v.exp_errs = e;
        vq.push_back(v);
    endtask

    task automatic run_byte(input logic [7:0] d, input logic bad, input int s,
                            input logic [3:0] c, input int e, input string tag);
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_bits(d, bad, 11);
        wclk(30);
        chk({tag, "_strobes"}, strobe_cnt - s0, s);
        if (s > 0) chk({tag, "_code"}, last_code, c);
        chk({tag, "_errs"}, err_cnt - e0, e);
    endtask

    initial begin
        int s0, e0;
        reset = 1'b0;
        ps2Clock = 1'b1;
        ps2Data = 1'b1;
        wclk(5);
        chk("reset_incode", inCode, 4'hF);
        chk("reset_valid", codeValid, 0);
        chk("reset_err", frameError, 0);
        reset = 1'b1;
        wclk(5);

        run_byte(8'h2D, 1'b0, 1, 4'h4, 0, "first_2d");
        chk("strobe_latency", strobe_cyc - stop_fall_cyc, 3);

        add(8'hE0, 0, 0, 4'h0, 0); add(8'h75, 0, 1, 4'h7, 0);
        add(8'hE0, 0, 0, 4'h0, 0); add(8'hF0, 0, 0, 4'h0, 0); add(8'h75, 0, 0, 4'h0, 0);
        add(8'h16, 1, 0, 4'h0, 1); add(8'h1E, 0, 1, 4'h2, 0);
        add(8'h75, 0, 0, 4'h0, 0); add(8'h1C, 0, 0, 4'h0, 0); add(8'h2B, 0, 1, 4'hD, 0);
        add(8'h45, 0, 1, 4'h0, 0); add(8'h16, 0, 1, 4'h1, 0); add(8'h26, 0, 1, 4'h3, 0);
        add(8'h34, 0, 1, 4'h5, 0); add(8'h32, 0, 1, 4'h6, 0);
        add(8'hE0, 0, 0, 4'h0, 0); add(8'h72, 0, 1, 4'h8, 0);
        add(8'hE0, 0, 0, 4'h0, 0); add(8'h6B, 0, 1, 4'h9, 0);
        add(8'hE0, 0, 0, 4'h0, 0); add(8'h74, 0, 1, 4'hA, 0);
        add(8'h79, 0, 1, 4'hB, 0); add(8'h7B, 0, 1, 4'hC, 0);
        add(8'hE0, 0, 0, 4'h0, 0); add(8'h45, 0, 0, 4'h0, 0);
        add(8'hF0, 0, 0, 4'h0, 0); add(8'h2D, 0, 0, 4'h0, 0);
        add(8'h2D, 0, 1, 4'h4, 0); add(8'h2D, 0, 1, 4'h4, 0);
        add(8'hE0, 0, 0, 4'h0, 0); add(8'h75, 1, 0, 4'h0, 1); add(8'h75, 0, 0, 4'h0, 0);

        for (int i = 0; i < vq.size(); i++)
            run_byte(vq[i].data, vq[i].bad, vq[i].exp_strobes, vq[i].exp_code,
                     vq[i].exp_errs, $sformatf("vec%0d", i));

        // Partial frame abandoned by timeout.
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_bits(8'h55, 1'b0, 5);
        wclk(int'(TMO) + 10);
        chk("timeout_errs", err_cnt - e0, 1);
        chk("timeout_strobes", strobe_cnt - s0, 0);
        run_byte(8'h79, 1'b0, 1, 4'hB, 0, "after_tmo");

        // Reset during bit 5 of a frame is silent.
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_bits(8'h2D, 1'b0, 6);
        ps2Data = 1'b1;
        ps2Clock = 1'b0;
        wclk(4);
        reset = 1'b0;
        wclk(4);
        ps2Clock = 1'b1;
        wclk(4);
        reset = 1'b1;
        wclk(int'(TMO) + 20);
        chk("midreset_errs", err_cnt - e0, 0);
        chk("midreset_strobes", strobe_cnt - s0, 0);
        run_byte(8'h45, 1'b0, 1, 4'h0, 0, "after_reset");

        chk("protocol_violations", viol_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_code_encode.md
# ps2_code_encode

Translates raw PS/2 keyboard traffic into the 4-bit command code consumed by the VGA character control logic. It receives PS/2 frames, strips break and extended prefixes, and maps each recognised make code to a one-cycle command strobe. Between strobes the code output sits at an idle value, so that downstream logic only acts once per key event.

## Interface

Parameters:
- TIMEOUT, 16'd50000: clock cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).
- IDLE_CODE, 4'hF: value driven on inCode when no command is present.

Ports:
- clock, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- ps2Clock, input, 1: PS/2 clock line, asynchronous.
- ps2Data, input, 1: PS/2 data line, asynchronous.
- inCode, output, 4: command code; holds IDLE_CODE except during the strobe cycle.
- codeValid, output, 1: high for exactly one cycle, coincident with a non-idle inCode.
- frameError, output, 1: one-cycle pulse on a parity, start-bit or stop-bit error, or on a timeout.

## Operation

Input conditioning:
- ps2Clock and ps2Data each pass through 2-flop synchronisers.
- A third register on ps2Clock provides falling-edge detection.
- Data is sampled on each detected falling edge.

Frame FSM (states IDLE, DATA, PARITY, STOP):
- IDLE: on a falling edge with data 0 (start bit), go to DATA and clear the bit count. Data 1 on a falling edge flags frameError and stays in IDLE.
- DATA: shift 8 bits in LSB first. After the 8th bit, go to PARITY.
- PARITY: latch the bit and go to STOP. A parity error is an even count of ones over data plus parity.
- STOP: stop bit 1 with good parity completes the byte and returns to IDLE. Otherwise flag frameError, discard the byte, clear the prefixes and return to IDLE.
- Timeout: a cycle counter resets on every falling edge. If it reaches TIMEOUT while not in IDLE, flag frameError and return to IDLE; prefixes are cleared.

Prefix handling on completed bytes:
- 8'hE0 sets extFlag.
- 8'hF0 sets brkFlag.
- Any other byte is a final byte, and both flags clear after it.
- If brkFlag was set, the final byte produces no output (key release).

Make-code map (ext = extFlag value when the final byte arrives):
- 45 → 0; 16 → 1; 1E → 2; 26 → 3.
- 2D (R) → 4; 34 (G) → 5; 32 (B) → 6.
- ext 75 → 7 (up); ext 72 → 8 (down); ext 6B → 9 (left); ext 74 → A (right).
- 79 (keypad +) → B; 7B (keypad −) → C; 2B (F) → D.
- Unmapped codes, and any mapped code arriving with the wrong ext state, produce no output and no error.
- Typematic repeats are fresh make codes and each produces a strobe.

## Timing

- Reset values: inCode = IDLE_CODE, codeValid = 0, frameError = 0. The FSM goes to IDLE, the shift register, bit count, flags and timeout counter are cleared, and the synchroniser and edge registers are set to 1.
- Reset asserted mid-frame abandons the frame silently; no frameError is raised.
- Falling edge to data sample: 3 clocks of synchroniser plus edge-detect latency.
- Strobe timing: inCode and codeValid assert on the clock after the cycle in which the stop-bit falling edge is detected. They return to IDLE_CODE and 0 on the following clock.
- frameError uses the same one-cycle timing relative to the detecting edge or the timeout.
- Minimum spacing between strobes is one full frame, so no back-to-back collisions occur.
- The timeout counter saturates at TIMEOUT and never wraps.

## Test plan

- Reset, then frame 8'h2D with good parity → one codeValid pulse with inCode = 4'h4. inCode stays 4'hF before and after.
- E0 75, then E0 F0 75 → exactly one strobe, inCode = 4'h7; the release produces nothing.
- Frame 8'h16 with bad parity → frameError pulse, no codeValid. A following good 8'h1E → inCode = 4'h2.
- 4 data bits of a frame, then idle for TIMEOUT+10 cycles → one frameError pulse. A subsequent full 8'h79 → inCode = 4'hB.
- 75 without the E0 prefix, then unmapped 1C → no strobe and no error. Then 2B → inCode = 4'hD.
- Reset driven low during bit 5 of a frame → no outputs. After release, a clean 8'h45 → inCode = 4'h0 with codeValid for one cycle.
